// File: rtl/enemy_fire_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : enemy_fire_scheduler_if
// Brief    : Handshake bundle between the fire scheduler and the ammo stage.
// Revision : 1.0 - initial release
// ============================================================================
interface enemy_fire_scheduler_if #(
    parameter int N = 2
);
    logic           enable;
    logic [N-1:0]   alive;
    logic           shot_busy;
    logic           fire;
    logic [7:0]     shot_idx;
    logic [7:0]     shot_col;
    logic [7:0]     shot_row;

    modport master (
        input  enable, alive, shot_busy,
        output fire, shot_idx, shot_col, shot_row
    );

    modport slave (
        output enable, alive, shot_busy,
        input  fire, shot_idx, shot_col, shot_row
    );
endinterface
`default_nettype wire

// File: rtl/enemy_fire_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : enemy_fire_scheduler
// Brief    : Picks when and which living enemy fires, one shot in flight.
// Revision : 1.0 - initial release
// ============================================================================
module enemy_fire_scheduler #(
    parameter int          LINHAS      = 1,
    parameter int          COLUNAS     = 2,
    parameter logic [23:0] BASE_DELAY  = 24'd5_000_000,
    parameter int          DELAY_SHIFT = 14,
    parameter int          ACK_TIMEOUT = 16,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   reset,
    enemy_fire_scheduler_if.master bus
);

    localparam int unsigned c_n_enemy   = LINHAS * COLUNAS;
    localparam logic [7:0]  c_last_ptr  = 8'(c_n_enemy - 1);
    localparam logic [15:0] c_ack_last  = 16'(ACK_TIMEOUT - 1);
    localparam logic [15:0] c_lfsr_mask = 16'hB400;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_SCAN = 3'd2,
        S_FIRE = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    state_t      r_state;
    logic [15:0] r_lfsr;
    logic [23:0] r_cnt;
    logic [7:0]  r_ptr;
    logic [7:0]  r_tried;
    logic [15:0] r_timer;
    logic        r_seen;
    logic        r_fire;
    logic [7:0]  r_idx;
    logic [7:0]  r_col;
    logic [7:0]  r_row;

    state_t      w_state_nxt;
    logic [15:0] w_lfsr_nxt;
    logic [23:0] w_cnt_nxt;
    logic [7:0]  w_ptr_nxt;
    logic [7:0]  w_tried_nxt;
    logic [15:0] w_timer_nxt;
    logic        w_seen_nxt;
    logic        w_fire_nxt;
    logic [7:0]  w_idx_nxt;
    logic [7:0]  w_col_nxt;
    logic [7:0]  w_row_nxt;

    logic [23:0]  w_rnd;
    logic [23:0]  w_reload;
    logic [7:0]   w_start;
    logic [7:0]   w_ptr_inc;
    logic [7:0]   w_ptr_col;
    logic [7:0]   w_ptr_row;
    logic [255:0] w_alive_ext;

    // Galois LFSR free-runs so the random draws depend on elapsed game time
    assign w_lfsr_nxt  = (r_lfsr >> 1) ^ (r_lfsr[0] ? c_lfsr_mask : 16'h0000);

    assign w_rnd       = {16'b0, r_lfsr[7:0]};
    assign w_reload    = BASE_DELAY + (w_rnd << DELAY_SHIFT);
    assign w_start     = 8'(32'(r_lfsr[15:8]) % c_n_enemy);
    assign w_ptr_inc   = (r_ptr == c_last_ptr) ? 8'd0 : r_ptr + 8'd1;
    assign w_ptr_col   = 8'(32'(r_ptr) % 32'(COLUNAS));
    assign w_ptr_row   = 8'(32'(r_ptr) / 32'(COLUNAS));
    assign w_alive_ext = 256'(bus.alive);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_tried_nxt = r_tried;
        w_timer_nxt = r_timer;
        w_seen_nxt  = r_seen;
        w_fire_nxt  = 1'b0;
        w_idx_nxt   = r_idx;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;

        if (!bus.enable) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = w_reload;
                end
                S_WAIT: begin
                    if (r_cnt != 24'd0) begin
                        w_cnt_nxt = r_cnt - 24'd1;
                    end else if (!bus.shot_busy) begin
                        w_state_nxt = S_SCAN;
                        w_ptr_nxt   = w_start;
                        w_tried_nxt = 8'd0;
                    end
                end
                S_SCAN: begin
                    // alive is sampled live so a target dying mid-scan is skipped
                    if (w_alive_ext[r_ptr]) begin
                        w_state_nxt = S_FIRE;
                        w_fire_nxt  = 1'b1;
                        w_idx_nxt   = r_ptr;
                        w_col_nxt   = w_ptr_col;
                        w_row_nxt   = w_ptr_row;
                    end else if (r_tried == c_last_ptr) begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = w_reload;
                    end else begin
                        w_ptr_nxt   = w_ptr_inc;
                        w_tried_nxt = r_tried + 8'd1;
                    end
                end
                S_FIRE: begin
                    w_state_nxt = S_HOLD;
                    w_timer_nxt = 16'd0;
                    w_seen_nxt  = 1'b0;
                end
                S_HOLD: begin
                    if (!r_seen) begin
                        if (bus.shot_busy) begin
                            w_seen_nxt = 1'b1;
                        end else if (r_timer == c_ack_last) begin
                            w_state_nxt = S_WAIT;
                            w_cnt_nxt   = w_reload;
                        end else begin
                            w_timer_nxt = r_timer + 16'd1;
                        end
                    end else if (!bus.shot_busy) begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = w_reload;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_lfsr  <= SEED;
            r_cnt   <= 24'd0;
            r_ptr   <= 8'd0;
            r_tried <= 8'd0;
            r_timer <= 16'd0;
            r_seen  <= 1'b0;
            r_fire  <= 1'b0;
            r_idx   <= 8'd0;
            r_col   <= 8'd0;
            r_row   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_lfsr  <= w_lfsr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_tried <= w_tried_nxt;
            r_timer <= w_timer_nxt;
            r_seen  <= w_seen_nxt;
            r_fire  <= w_fire_nxt;
            r_idx   <= w_idx_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
        end
    end

    assign bus.fire     = r_fire;
    assign bus.shot_idx = r_idx;
    assign bus.shot_col = r_col;
    assign bus.shot_row = r_row;

endmodule
`default_nettype wire

// File: tb/tb_enemy_fire_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_enemy_fire_scheduler
// Brief    : Randomized bench for the enemy fire scheduler with a timing model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_enemy_fire_scheduler;

    localparam int NA     = 2;
    localparam int BASE_A = 4;
    localparam int ACK_A  = 16;
    localparam logic [15:0] SEED = 16'hACE1;

    localparam int M_OFF = 0, M_DELAY = 1, M_SEARCH = 2, M_LAUNCH = 3, M_ACK = 4;
    localparam int P_PULSE = 0, P_HOLD = 1, P_NONE = 2, P_RAND = 3;

    logic clk = 1'b0;
    logic reset;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    enemy_fire_scheduler_if #(.N(NA)) a_if ();
    enemy_fire_scheduler_if #(.N(12)) b_if ();

    enemy_fire_scheduler #(
        .LINHAS(1), .COLUNAS(2), .BASE_DELAY(24'd4), .DELAY_SHIFT(0),
        .ACK_TIMEOUT(16), .SEED(16'hACE1)
    ) dut_a (.clk(clk), .reset(reset), .bus(a_if));

    enemy_fire_scheduler #(
        .LINHAS(3), .COLUNAS(4), .BASE_DELAY(24'd4), .DELAY_SHIFT(2),
        .ACK_TIMEOUT(16), .SEED(16'hACE1)
    ) dut_b (.clk(clk), .reset(reset), .bus(b_if));

    // ---------------- reference model for DUT A (absolute-time events) -----
    logic [15:0] m_lfsr;
    int          m_t = 0;
    int          m_mode = M_OFF;
    int          m_ready, m_fire_at, m_fail_at, m_hold, m_start, m_tgt;
    bit          m_found, m_seen;
    logic        m_fire = 1'b0;
    logic [7:0]  m_idx = 8'd0;

    function automatic int delay_of(input logic [15:0] l);
        return BASE_A + int'(l[7:0]);
    endfunction

    always @(posedge clk) begin
        m_fire = 1'b0;
        if (reset) begin
            m_lfsr = SEED;
            m_mode = M_OFF;
            m_idx  = 8'd0;
        end else begin
            if (!a_if.enable) begin
                m_mode = M_OFF;
            end else begin
                case (m_mode)
                    M_OFF: begin
                        m_mode  = M_DELAY;
                        m_ready = m_t + delay_of(m_lfsr);
                    end
                    M_DELAY: begin
                        if (m_t > m_ready && !a_if.shot_busy) begin
                            m_start = int'(m_lfsr[15:8]) % NA;
                            m_found = 1'b0;
                            for (int j = 0; j < NA; j++) begin
                                if (!m_found && a_if.alive[(m_start + j) % NA]) begin
                                    m_found   = 1'b1;
                                    m_tgt     = (m_start + j) % NA;
                                    m_fire_at = m_t + j + 1;
                                end
                            end
                            m_fail_at = m_t + NA;
                            m_mode    = M_SEARCH;
                        end
                    end
                    M_SEARCH: begin
                        if (m_found && m_t == m_fire_at) begin
                            m_fire = 1'b1;
                            m_idx  = 8'(m_tgt);
                            m_mode = M_LAUNCH;
                        end else if (!m_found && m_t == m_fail_at) begin
                            m_mode  = M_DELAY;
                            m_ready = m_t + delay_of(m_lfsr);
                        end
                    end
                    M_LAUNCH: begin
                        m_mode = M_ACK;
                        m_hold = m_t;
                        m_seen = 1'b0;
                    end
                    default: begin
                        if (!m_seen) begin
                            if (a_if.shot_busy) begin
                                m_seen = 1'b1;
                            end else if (m_t - m_hold == ACK_A) begin
                                m_mode  = M_DELAY;
                                m_ready = m_t + delay_of(m_lfsr);
                            end
                        end else if (!a_if.shot_busy) begin
                            m_mode  = M_DELAY;
                            m_ready = m_t + delay_of(m_lfsr);
                        end
                    end
                endcase
            end
            m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        end
        m_t++;
    end

    // ---------------- stimulus helpers --------------------------------------
    int rsp_wait = -1;
    int rsp_len  = 0;

    task automatic apply_reset();
        reset = 1'b1;
        a_if.enable = 1'b0; a_if.shot_busy = 1'b0; a_if.alive = '0;
        b_if.enable = 1'b0; b_if.shot_busy = 1'b0; b_if.alive = '0;
        rsp_wait = -1; rsp_len = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // ammo-stage responder for DUT A, reacting to the model's launches
    task automatic drive_busy(input int policy);
        if (m_fire) begin
            rsp_wait = (policy == P_RAND) ? int'($urandom_range(0, 4)) : 3;
            rsp_len  = (policy == P_RAND) ? int'($urandom_range(1, 5)) : 2;
        end else if (rsp_wait > 0) begin
            rsp_wait--;
        end
        case (policy)
            P_HOLD:  a_if.shot_busy = a_if.shot_busy | m_fire;
            P_NONE:  a_if.shot_busy = 1'b0;
            default: begin
                if (rsp_wait == 0 && rsp_len > 0) begin
                    a_if.shot_busy = 1'b1;
                    rsp_len--;
                end else begin
                    a_if.shot_busy = (policy == P_RAND) && ($urandom_range(0, 19) == 0);
                end
            end
        endcase
    endtask

    // ---------------- tests --------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        a_if.enable = 1'b0; a_if.shot_busy = 1'b0; a_if.alive = '0;
        b_if.enable = 1'b0; b_if.shot_busy = 1'b0; b_if.alive = '0;
        repeat (2) @(negedge clk);
        n_total++;
        if (a_if.fire !== 1'b0 || b_if.fire !== 1'b0) begin
            n_bad++; $display("FAIL reset_fire a=%b b=%b exp=0", a_if.fire, b_if.fire);
        end
        n_total++;
        if ({a_if.shot_idx, a_if.shot_col, a_if.shot_row} !== 24'd0) begin
            n_bad++; $display("FAIL reset_shot_a got=%h exp=000000", {a_if.shot_idx, a_if.shot_col, a_if.shot_row});
        end
        n_total++;
        if ({b_if.shot_idx, b_if.shot_col, b_if.shot_row} !== 24'd0) begin
            n_bad++; $display("FAIL reset_shot_b got=%h exp=000000", {b_if.shot_idx, b_if.shot_col, b_if.shot_row});
        end
        n_total++;
        if (dut_a.r_lfsr !== 16'hACE1) begin
            n_bad++; $display("FAIL reset_lfsr got=%h exp=ace1", dut_a.r_lfsr);
        end
        reset = 1'b0;
        @(negedge clk);
        n_total++;
        if (dut_a.r_lfsr !== 16'hE270) begin
            n_bad++; $display("FAIL lfsr_step1 got=%h exp=e270", dut_a.r_lfsr);
        end
        @(negedge clk);
        n_total++;
        if (dut_a.r_lfsr !== 16'h7138) begin
            n_bad++; $display("FAIL lfsr_step2 got=%h exp=7138", dut_a.r_lfsr);
        end
    endtask

    task automatic test_dead_skip();
        int  last = -1;
        int  fires = 0;
        bit  ok = 1'b1;
        apply_reset();
        a_if.alive = 2'b10; a_if.enable = 1'b1;
        for (int c = 0; c < 3000 && ok; c++) begin
            @(negedge clk);
            n_total++;
            if (a_if.fire !== m_fire) begin
                n_bad++; ok = 1'b0;
                $display("FAIL skip_fire t=%0d got=%b exp=%b", m_t, a_if.fire, m_fire);
            end else if (m_fire) begin
                fires++;
                n_total++;
                if ({a_if.shot_idx, a_if.shot_col, a_if.shot_row} !== {8'd1, 8'd1, 8'd0}) begin
                    n_bad++; ok = 1'b0;
                    $display("FAIL skip_target got=%0d/%0d/%0d exp=1/1/0", a_if.shot_idx, a_if.shot_col, a_if.shot_row);
                end
                if (last >= 0) begin
                    n_total++;
                    if (c - last < 4) begin
                        n_bad++; ok = 1'b0;
                        $display("FAIL skip_gap got=%0d exp>=4", c - last);
                    end
                end
                last = c;
            end
            drive_busy(P_PULSE);
        end
        n_total++;
        if (fires < 2) begin
            n_bad++; $display("FAIL skip_count got=%0d exp>=2", fires);
        end
    endtask

    task automatic test_all_dead();
        bit ok = 1'b1;
        apply_reset();
        a_if.alive = 2'b00; a_if.enable = 1'b1;
        for (int c = 0; c < 4000 && ok; c++) begin
            @(negedge clk);
            n_total++;
            if (a_if.fire !== 1'b0) begin
                n_bad++; ok = 1'b0;
                $display("FAIL all_dead_fire cyc=%0d got=%b exp=0", c, a_if.fire);
            end
        end
    endtask

    task automatic test_busy_handshake();
        int  fires = 0;
        int  last = -1;
        bit  ok = 1'b1;
        apply_reset();
        a_if.alive = 2'b11; a_if.enable = 1'b1;
        for (int c = 0; c < 1500 && ok; c++) begin
            @(negedge clk);
            n_total++;
            if (a_if.fire !== m_fire) begin
                n_bad++; ok = 1'b0;
                $display("FAIL busy_hold_fire t=%0d got=%b exp=%b", m_t, a_if.fire, m_fire);
            end
            if (a_if.fire === 1'b1) fires++;
            drive_busy(P_HOLD);
        end
        n_total++;
        if (fires != 1) begin
            n_bad++; $display("FAIL busy_hold_count got=%0d exp=1", fires);
        end

        apply_reset();
        a_if.alive = 2'b11; a_if.enable = 1'b1;
        fires = 0; ok = 1'b1;
        for (int c = 0; c < 1500 && ok; c++) begin
            @(negedge clk);
            n_total++;
            if (a_if.fire !== m_fire) begin
                n_bad++; ok = 1'b0;
                $display("FAIL busy_lost_fire t=%0d got=%b exp=%b", m_t, a_if.fire, m_fire);
            end else if (m_fire) begin
                fires++;
                if (last >= 0) begin
                    n_total++;
                    if (c - last < 23) begin
                        n_bad++; ok = 1'b0;
                        $display("FAIL busy_lost_gap got=%0d exp>=23", c - last);
                    end
                end
                last = c;
            end
            drive_busy(P_NONE);
        end
        n_total++;
        if (fires < 2) begin
            n_bad++; $display("FAIL busy_lost_count got=%0d exp>=2", fires);
        end
    endtask

    task automatic test_disable_reset();
        bit found = 1'b0;
        bit ok = 1'b1;
        apply_reset();
        a_if.alive = 2'b10; a_if.enable = 1'b1;
        for (int c = 0; c < 800 && ok && !found; c++) begin
            @(negedge clk);
            n_total++;
            if (a_if.fire !== m_fire) begin
                n_bad++; ok = 1'b0;
                $display("FAIL dis_pre_fire t=%0d got=%b exp=%b", m_t, a_if.fire, m_fire);
            end
            if (m_mode == M_SEARCH) found = 1'b1;
            else drive_busy(P_NONE);
        end
        n_total++;
        if (!found) begin
            n_bad++; $display("FAIL dis_reach_scan got=0 exp=1");
        end
        a_if.enable = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_total++;
            if (a_if.fire !== 1'b0) begin
                n_bad++; $display("FAIL dis_scan_fire cyc=%0d got=%b exp=0", c, a_if.fire);
            end
        end
        a_if.enable = 1'b1;
        found = 1'b0; ok = 1'b1;
        for (int c = 0; c < 800 && ok && !found; c++) begin
            @(negedge clk);
            n_total++;
            if (a_if.fire !== m_fire) begin
                n_bad++; ok = 1'b0;
                $display("FAIL dis_resume_fire t=%0d got=%b exp=%b", m_t, a_if.fire, m_fire);
            end
            if (m_mode == M_ACK) found = 1'b1;
            else drive_busy(P_NONE);
        end
        n_total++;
        if (!found || a_if.shot_idx !== 8'd1) begin
            n_bad++; $display("FAIL dis_reach_hold idx=%0d found=%0d exp=1/1", a_if.shot_idx, found);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_total++;
        if (a_if.fire !== 1'b0 || {a_if.shot_idx, a_if.shot_col, a_if.shot_row} !== 24'd0) begin
            n_bad++; $display("FAIL hold_reset_out fire=%b shot=%h exp=0/000000", a_if.fire, {a_if.shot_idx, a_if.shot_col, a_if.shot_row});
        end
        n_total++;
        if (dut_a.r_lfsr !== 16'hACE1) begin
            n_bad++; $display("FAIL hold_reset_lfsr got=%h exp=ace1", dut_a.r_lfsr);
        end
    endtask

    task automatic test_random();
        int policy;
        int len;
        bit ok = 1'b1;
        apply_reset();
        for (int ep = 0; ep < 8 && ok; ep++) begin
            a_if.enable = 1'b0;
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                n_total++;
                if (a_if.fire !== m_fire) begin
                    n_bad++; ok = 1'b0;
                    $display("FAIL rand_off_fire ep=%0d got=%b exp=%b", ep, a_if.fire, m_fire);
                end
            end
            a_if.alive = 2'($urandom_range(0, 3));
            policy = int'($urandom_range(0, 3));
            len = int'($urandom_range(300, 1500));
            a_if.shot_busy = 1'b0; rsp_wait = -1; rsp_len = 0;
            a_if.enable = 1'b1;
            for (int c = 0; c < len && ok; c++) begin
                @(negedge clk);
                reset = 1'b0;
                n_total++;
                if (a_if.fire !== m_fire) begin
                    n_bad++; ok = 1'b0;
                    $display("FAIL rand_fire ep=%0d t=%0d got=%b exp=%b", ep, m_t, a_if.fire, m_fire);
                end else if (m_fire) begin
                    n_total++;
                    if ({a_if.shot_idx, a_if.shot_col, a_if.shot_row} !== {m_idx, 8'(m_idx % 2), 8'(m_idx / 2)}) begin
                        n_bad++; ok = 1'b0;
                        $display("FAIL rand_target ep=%0d got=%0d/%0d/%0d exp_idx=%0d", ep, a_if.shot_idx, a_if.shot_col, a_if.shot_row, m_idx);
                    end
                end
                drive_busy(policy);
                if (ep == 5 && c == len / 2) reset = 1'b1;
            end
        end
    endtask

    task automatic test_grid();
        logic [11:0] pat;
        int          bitn;
        bit          got;
        apply_reset();
        for (int r = 0; r < 8; r++) begin
            b_if.enable = 1'b0; b_if.shot_busy = 1'b0;
            repeat (2) @(negedge clk);
            bitn = (r == 0) ? 9 : int'($urandom_range(0, 11));
            pat  = (r < 5) ? (12'd1 << bitn) : (12'($urandom) | 12'h001);
            b_if.alive = pat;
            b_if.enable = 1'b1;
            got = 1'b0;
            for (int c = 0; c < 2500 && !got; c++) begin
                @(negedge clk);
                if (b_if.fire === 1'b1) got = 1'b1;
            end
            n_total++;
            if (!got) begin
                n_bad++; $display("FAIL grid_timeout round=%0d got=0 exp=1", r);
            end else if (r < 5) begin
                n_total++;
                if ({b_if.shot_idx, b_if.shot_col, b_if.shot_row} !== {8'(bitn), 8'(bitn % 4), 8'(bitn / 4)}) begin
                    n_bad++;
                    $display("FAIL grid_decode round=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", r, b_if.shot_idx, b_if.shot_col, b_if.shot_row, bitn, bitn % 4, bitn / 4);
                end
            end else begin
                n_total++;
                if (b_if.shot_idx >= 8'd12 || pat[b_if.shot_idx[3:0]] !== 1'b1 ||
                    b_if.shot_col !== 8'(int'(b_if.shot_idx) % 4) || b_if.shot_row !== 8'(int'(b_if.shot_idx) / 4)) begin
                    n_bad++;
                    $display("FAIL grid_alive round=%0d pat=%h got=%0d/%0d/%0d", r, pat, b_if.shot_idx, b_if.shot_col, b_if.shot_row);
                end
            end
            if (got) begin
                @(negedge clk);
                n_total++;
                if (b_if.fire !== 1'b0) begin
                    n_bad++; $display("FAIL grid_width round=%0d got=%b exp=0", r, b_if.fire);
                end
            end
        end
        b_if.enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_dead_skip();
        test_all_dead();
        test_busy_handshake();
        test_disable_reset();
        test_random();
        test_grid();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
